// File: rtl/clk_div_gen_pkg.sv
// rtl/clk_div_gen_pkg.sv - state codes, ratio limits and phase-split helper for clk_div_gen
package clk_div_gen_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    localparam int MIN_DIV_RATIO    = 2;
    localparam int BYPASS_MAX_RATIO = 1;

    typedef struct packed {
        logic [31:0] high_len;
        logic [31:0] low_len;
    } phase_t;

    // Odd ratios put the extra cycle in the low phase.
    function automatic phase_t phase_split(input logic [31:0] n);
        phase_t p;
        p.high_len = n >> 1;
        p.low_len  = n - (n >> 1);
        return p;
    endfunction

endpackage

// File: rtl/clk_div_neg_stage.sv
// rtl/clk_div_neg_stage.sv - negedge half-cycle stretch for 50% duty on odd ratios
module clk_div_neg_stage (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic q_i,
    input  logic odd_i,
    output logic clk_o
);

    logic q_neg_q;

    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_i;
        end
    end

    assign clk_o = odd_i ? (q_i | q_neg_q) : q_i;

endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - glitch-free runtime integer clock divider with period-boundary strobe
// Optional 50% duty for odd ratios: define CLK_DIV_GEN_ODD_DUTY50_EN.
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int RATIO_W   = 8,
    parameter int RST_RATIO = 1
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    input  logic [RATIO_W-1:0] i_div_ratio,
    output logic               o_div_clk,
    output logic [RATIO_W-1:0] o_active_ratio,
    output logic               o_bypass,
    output logic               o_period_done
);

    logic [1:0]         state_q, state_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic               en_q, en_d;
    logic               q_q, q_d;
    phase_t             phase;
    logic [RATIO_W-1:0] high_last, low_last;
    logic               boundary;
    logic               shaped_clk;

    assign phase     = phase_split(32'(ratio_q));
    assign high_last = RATIO_W'(phase.high_len - 32'd1);
    assign low_last  = RATIO_W'(phase.low_len - 32'd1);

    assign o_period_done = (state_q == S_LOW) && (cnt_q == low_last);
    assign boundary      = (state_q == S_IDLE) || o_period_done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        en_d    = en_q;
        if (boundary) begin
            ratio_d = i_div_ratio;
            en_d    = i_clk_en;
            cnt_d   = '0;
            if (i_clk_en && (i_div_ratio >= RATIO_W'(MIN_DIV_RATIO))) begin
                state_d = S_HIGH;
            end else begin
                state_d = S_IDLE;
            end
        end else if (state_q == S_HIGH) begin
            if (cnt_q == high_last) begin
                state_d = S_LOW;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        q_d = (state_d == S_HIGH);
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ratio_q <= RATIO_W'(RST_RATIO);
            en_q    <= 1'b0;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            en_q    <= en_d;
            q_q     <= q_d;
        end
    end

    assign o_active_ratio = ratio_q;
    assign o_bypass       = (ratio_q <= RATIO_W'(BYPASS_MAX_RATIO));

`ifdef CLK_DIV_GEN_ODD_DUTY50_EN
    logic odd_ratio;
    // Odd and above the bypass limit means odd N >= 3.
    assign odd_ratio = ratio_q[0] && !o_bypass;

    clk_div_neg_stage u_neg_stage (
        .clk_i   (i_ref_clk),
        .rst_n_i (i_rst_n),
        .q_i     (q_q),
        .odd_i   (odd_ratio),
        .clk_o   (shaped_clk)
    );
`else
    assign shaped_clk = q_q;
`endif

    assign o_div_clk = !en_q     ? 1'b0 :
                       o_bypass  ? i_ref_clk :
                                   shaped_clk;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - self-checking bench for clk_div_gen against a period-position model
module tb_clk_div_gen;

    logic       ref_clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic [7:0] div_ratio;
    logic       div_clk;
    logic [7:0] active_ratio;
    logic       bypass;
    logic       period_done;

    int checks = 0;
    int errors = 0;

    // Model: position inside the current divided period, or idle.
    bit m_idle;
    int m_pos;
    int m_n;
    bit m_en;
    bit m_qneg;

    clk_div_gen #(.RATIO_W(8), .RST_RATIO(1)) dut (
        .i_ref_clk      (ref_clk),
        .i_rst_n        (rst_n),
        .i_clk_en       (clk_en),
        .i_div_ratio    (div_ratio),
        .o_div_clk      (div_clk),
        .o_active_ratio (active_ratio),
        .o_bypass       (bypass),
        .o_period_done  (period_done)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_q();
        return !m_idle && (m_pos < m_n / 2);
    endfunction

    function automatic bit exp_div(input bit ref_level);
        if (!m_en) return 1'b0;
        if (m_n <= 1) return ref_level;
`ifdef CLK_DIV_GEN_ODD_DUTY50_EN
        if ((m_n % 2) == 1) return exp_q() | m_qneg;
`endif
        return exp_q();
    endfunction

    task automatic model_reset();
        m_idle = 1'b1;
        m_pos  = 0;
        m_n    = 1;
        m_en   = 1'b0;
        m_qneg = 1'b0;
    endtask

    task automatic model_edge(input bit en, input int n);
        if (m_idle || (m_pos == m_n - 1)) begin
            m_n  = n;
            m_en = en;
            m_pos = 0;
            m_idle = !(en && n >= 2);
        end else begin
            m_pos++;
        end
    endtask

    // Called just after a falling edge; returns the outputs seen after the next rising edge.
    task automatic cycle(input bit en, input logic [7:0] n, output logic dclk, output logic done);
        clk_en    = en;
        div_ratio = n;
        @(posedge ref_clk);
        model_edge(en, int'(n));
        #1;
        check("div_clk_hi", div_clk, exp_div(1'b1));
        check("period_done", period_done, !m_idle && (m_pos == m_n - 1));
        check("active_ratio", active_ratio, m_n);
        check("bypass", bypass, m_n <= 1);
        dclk = div_clk;
        done = period_done;
        @(negedge ref_clk);
        m_qneg = exp_q();
        #1;
        check("div_clk_lo", div_clk, exp_div(1'b0));
    endtask

    logic d, p;
    int   hc;
    bit   seen;

    initial begin
        rst_n = 1'b0;
        clk_en = 1'b0;
        div_ratio = 8'd0;
        model_reset();
        repeat (3) @(posedge ref_clk);
        @(negedge ref_clk);
        #1;
        check("rst_div_clk", div_clk, 0);
        check("rst_done", period_done, 0);
        check("rst_ratio", active_ratio, 1);
        check("rst_bypass", bypass, 1);
        rst_n = 1'b1;

        // N = 4 straight out of reset: 1,1,0,0 with done on the second low cycle.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 8'd4, d, p);
            check("n4_pattern", d, (i % 4) < 2);
            check("n4_done", p, (i % 4) == 3);
        end

        // N = 5: boundary falls on the same cycle as the last N=4 period end.
        for (int i = 0; i < 15; i++) cycle(1'b1, 8'd5, d, p);

        // Move to N = 4, then request 6 during the first high cycle.
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1'b1, 8'd4, d, p);
            if (p) seen = 1;
        end
        check("n5_boundary_seen", seen, 1);
        cycle(1'b1, 8'd4, d, p);
        check("n4_before_change", active_ratio, 4);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'd6, d, p);
            check("n4_keeps_ratio", active_ratio, 4);
        end
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'd6, d, p);
        check("n6_ratio", active_ratio, 6);

        // N = 8, drop enable during the low phase.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'd8, d, p);
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'd8, d, p);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'd8, d, p);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'd8, d, p);
            check("disabled_div", d, 0);
            check("disabled_done", p, 0);
        end

        // Bypass, then N = 3 enters high on the next edge.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'd1, d, p);
            check("bypass_flag", bypass, 1);
        end
        cycle(1'b1, 8'd3, d, p);
        check("n3_first_high", d, 1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'd3, d, p);

        // N = 255, asynchronous reset during the high phase.
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'd255, d, p);
        check("n255_high_before_rst", div_clk, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_div", div_clk, 0);
        check("async_rst_ratio", active_ratio, 1);
        model_reset();
        @(negedge ref_clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'd255, d, p);
            check("post_rst_idle", d, 0);
        end
        hc = 0;
        seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            cycle(1'b1, 8'd255, d, p);
            if (d) hc++;
            if (p) seen = 1;
        end
        check("n255_period_end", seen, 1);
`ifdef CLK_DIV_GEN_ODD_DUTY50_EN
        check("n255_high_cycles", hc, 128);
`else
        check("n255_high_cycles", hc, 127);
`endif

        // Random enable/ratio traffic against the model.
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom % 8) != 0,
                  (($urandom % 5) == 0) ? 8'($urandom % 256) : 8'($urandom % 10), d, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
